uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 15 +
 rtl/uart_rx_fifo_byte_fifo.sv | 64 ++++++
 rtl/uart_rx_fifo.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the uart_rx_fifo receiver.
package uart_rx_fifo_pkg;

    localparam int UART_CLKS_115200_25MHZ = 217;
    localparam int CNT_W                  = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// rx_byte_fifo: circular byte store with wrap-bit pointers; DEPTH must be a power of two (1 allowed).
module rx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] WRAP = PW'(1) << (PW - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          wr_en, rd_en;

    if (DEPTH > 1) begin : g_idx
        assign wr_idx = wr_ptr_q[AW-1:0];
        assign rd_idx = rd_ptr_q[AW-1:0];
    end else begin : g_idx_single
        assign wr_idx = '0;
        assign rd_idx = '0;
    end

    // Pointers differ only in the wrap bit when every slot holds data.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = ((wr_ptr_q ^ rd_ptr_q) == WRAP);
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = empty ? 8'h00 : mem_q[rd_idx];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; empty pointers plus the pop_data mask hide stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with sticky error flags. Define UART_RX_FIFO_EN for a
// FIFO_DEPTH-entry receive FIFO; otherwise a single holding register stores the byte.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_115200_25MHZ,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic       framing_err,
    output logic       overrun,
    input  logic       clr_err,
    output logic       busy
);

    if (CLKS_PER_BIT < 16 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_rx_fifo: CLKS_PER_BIT must be within 16..65535");
    end
    if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of two");
    end

`ifdef UART_RX_FIFO_EN
    localparam int STORE_DEPTH = FIFO_DEPTH;
`else
    localparam int STORE_DEPTH = 1;
`endif

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q, sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic             rx_s, rx_fall;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             framing_err_q, framing_err_d;
    logic             overrun_q, overrun_d;
    logic             push, set_framing, set_overrun, pop;
    logic             fifo_full, fifo_empty;

    assign rx_s    = sync_q[1];
    assign rx_fall = rx_prev_q && !rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d = START;
                    cnt_d   = HALF_BIT;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rx_s) begin
                    state_d   = DATA;
                    cnt_d     = FULL_BIT;
                    bit_idx_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d[bit_idx_q] = rx_s;
                    cnt_d              = FULL_BIT;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        push        = (state_q == STOP) && (cnt_q == '0) && rx_s;
        set_framing = (state_q == STOP) && (cnt_q == '0) && !rx_s;
    end

    // Synchronizer resets high so a released line does not look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= 2'b11;
            rx_prev_q     <= 1'b1;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            rx_prev_q     <= rx_prev_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    // A same-cycle set wins over clr_err.
    always_comb begin
        sync_d        = {sync_q[0], rxd};
        rx_prev_d     = rx_s;
        pop           = rd_valid && rd_ready;
        set_overrun   = push && fifo_full && !pop;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;
        if (clr_err) begin
            framing_err_d = 1'b0;
            overrun_d     = 1'b0;
        end
        if (set_framing) framing_err_d = 1'b1;
        if (set_overrun) overrun_d     = 1'b1;
    end

    rx_byte_fifo #(
        .DEPTH(STORE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(shift_q),
        .pop      (pop),
        .pop_data (rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rd_valid    = !fifo_empty;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule
